// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared default constants for the UART baud-rate tick
//                generator and its fractional divider.
//                  c_DIV_W   - integer divisor width
//                  c_FRAC_W  - fractional divisor width (step 1/2^FRAC_W)
//                  c_OVS     - oversampling factor (power of two, >= 4)
//                  c_DIV_RST - integer divisor value after reset
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_DIV_W   = 16;
    localparam int unsigned c_FRAC_W  = 4;
    localparam int unsigned c_OVS     = 16;
    localparam int unsigned c_DIV_RST = 1;

    // Width of the os_tick-within-bit phase counter for a given oversampling
    // factor. OVS is a power of two, so the counter wraps naturally.
    function automatic int unsigned phase_width(input int unsigned ovs);
        return $clog2(ovs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frac_div.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frac_div
//  Description : Fractional clock divider producing the oversampling tick.
//                Average os_tick period is N + F/2^FRAC_W clk cycles, where
//                N = max(div_act, 1) and F = frac_act. A shadow register
//                captures software writes; the active register only follows
//                it at period boundaries, so a period is never cut short.
//
//  Ports       : clk       in   clock, rising edge
//                rst       in   synchronous active-high reset
//                en        in   run enable; low clears the counters
//                sync      in   restart the period from the current edge
//                div_load  in   capture clk_div/clk_frac into the shadow
//                clk_div   in   integer part N of the period
//                clk_frac  in   fractional part F of the period
//                os_tick   out  registered one-cycle oversampling tick
//                tick_evt  out  combinational strobe: os_tick is set at
//                               this edge (lets the parent update state in
//                               step with os_tick)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int unsigned          DIV_W   = c_DIV_W,
    parameter int unsigned          FRAC_W  = c_FRAC_W,
    parameter logic [DIV_W-1:0]     DIV_RST = DIV_W'(c_DIV_RST)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic                div_load,
    input  logic [DIV_W-1:0]    clk_div,
    input  logic [FRAC_W-1:0]   clk_frac,
    output logic                os_tick,
    output logic                tick_evt
);

    localparam logic [DIV_W-1:0] c_ZERO = '0;
    localparam logic [DIV_W-1:0] c_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0]   r_div_sh;
    logic [FRAC_W-1:0]  r_frac_sh;
    logic [DIV_W-1:0]   r_div_act;
    logic [FRAC_W-1:0]  r_frac_act;
    logic [DIV_W-1:0]   r_cnt;
    logic [FRAC_W-1:0]  r_acc;
    logic               r_extra;        // current period is one cycle longer
    logic               r_os_tick;

    logic [DIV_W-1:0]   w_div_sh_nxt;
    logic [FRAC_W-1:0]  w_frac_sh_nxt;
    logic [DIV_W-1:0]   w_n_eff;
    logic [DIV_W:0]     w_term;
    logic               w_last;
    logic [FRAC_W:0]    w_sum;
    logic [DIV_W-1:0]   w_sync_cnt;

    // A write in the same cycle as a period boundary is forwarded straight
    // into the active register, so the period starting at that boundary
    // (including the first one after enable or sync) uses the new value.
    assign w_div_sh_nxt  = div_load ? clk_div  : r_div_sh;
    assign w_frac_sh_nxt = div_load ? clk_frac : r_frac_sh;

    // A divisor of 0 behaves as 1 so the counter can never stall.
    assign w_n_eff = (r_div_act == c_ZERO) ? c_ONE : r_div_act;

    // Terminal count of the current period: N_eff - 1 + carry. One extra bit
    // keeps the compare exact when N_eff is at its maximum.
    assign w_term = {1'b0, w_n_eff} - {1'b0, c_ONE} + {{DIV_W{1'b0}}, r_extra};
    assign w_last = ({1'b0, r_cnt} == w_term);

    assign w_sum = {1'b0, r_acc} + {1'b0, r_frac_act};

    // The sync edge itself counts as the first cycle of the new period, so
    // the counter restarts at 1. With N_eff = 1 that would skip the terminal
    // value, so it restarts at 0 and the tick follows on the next edge.
    assign w_sync_cnt = (w_div_sh_nxt > c_ONE) ? c_ONE : c_ZERO;

    assign tick_evt = en && !sync && w_last;
    assign os_tick  = r_os_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_sh   <= DIV_RST;
            r_frac_sh  <= '0;
            r_div_act  <= DIV_RST;
            r_frac_act <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_extra    <= 1'b0;
            r_os_tick  <= 1'b0;
        end else begin
            r_div_sh  <= w_div_sh_nxt;
            r_frac_sh <= w_frac_sh_nxt;

            if (!en) begin
                r_div_act  <= w_div_sh_nxt;
                r_frac_act <= w_frac_sh_nxt;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_extra    <= 1'b0;
                r_os_tick  <= 1'b0;
            end else if (sync) begin
                r_div_act  <= w_div_sh_nxt;
                r_frac_act <= w_frac_sh_nxt;
                r_cnt      <= w_sync_cnt;
                r_acc      <= '0;
                r_extra    <= 1'b0;
                r_os_tick  <= 1'b0;
            end else if (w_last) begin
                r_div_act  <= w_div_sh_nxt;
                r_frac_act <= w_frac_sh_nxt;
                r_cnt      <= '0;
                r_acc      <= w_sum[FRAC_W-1:0];
                r_extra    <= w_sum[FRAC_W];
                r_os_tick  <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + c_ONE;
                r_os_tick <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick_gen
//  Description : Baud-rate tick generator. A fractional divider produces the
//                oversampling tick; a phase counter on top of it produces the
//                1x transmit tick and the mid-bit receive sample tick.
//
//  Ports       : clk       in   clock, rising edge
//                rst       in   synchronous active-high reset
//                en        in   run enable; low holds counters at 0
//                sync      in   restart the bit phase (receiver start edge)
//                div_load  in   capture clk_div/clk_frac into the shadow
//                clk_div   in   integer part N of the os_tick period
//                clk_frac  in   fractional part F of the os_tick period
//                os_tick   out  one-cycle oversampling tick
//                tx_tick   out  one-cycle pulse every OVS os_ticks
//                mid_tick  out  one-cycle pulse at the OVS/2-th os_tick
//                os_phase  out  os_tick count within the current bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned          DIV_W   = c_DIV_W,
    parameter int unsigned          FRAC_W  = c_FRAC_W,
    parameter int unsigned          OVS     = c_OVS,
    parameter logic [DIV_W-1:0]     DIV_RST = DIV_W'(c_DIV_RST)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        sync,
    input  logic                        div_load,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic [FRAC_W-1:0]           clk_frac,
    output logic                        os_tick,
    output logic                        tx_tick,
    output logic                        mid_tick,
    output logic [$clog2(OVS)-1:0]      os_phase
);

    localparam int unsigned         c_PH_W       = phase_width(OVS);
    localparam logic [c_PH_W-1:0]   c_PH_ONE     = {{(c_PH_W-1){1'b0}}, 1'b1};
    // Phase values seen at the tick edge, i.e. one before the value the
    // phase is about to take.
    localparam logic [c_PH_W-1:0]   c_PH_LAST    = c_PH_W'(OVS - 1);
    localparam logic [c_PH_W-1:0]   c_PH_PRE_MID = c_PH_W'(OVS / 2 - 1);

    logic               w_tick_evt;
    logic [c_PH_W-1:0]  r_phase;
    logic               r_tx_tick;
    logic               r_mid_tick;

    uart_frac_div #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DIV_RST  (DIV_RST)
    ) u_frac_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .div_load (div_load),
        .clk_div  (clk_div),
        .clk_frac (clk_frac),
        .os_tick  (os_tick),
        .tick_evt (w_tick_evt)
    );

    // The phase advances on the same edge that raises os_tick, so os_phase
    // already shows the new count while os_tick is high. OVS is a power of
    // two, so the increment wraps from OVS-1 to 0 by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= '0;
            r_tx_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
        end else if (!en || sync) begin
            r_phase    <= '0;
            r_tx_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
        end else if (w_tick_evt) begin
            r_phase    <= r_phase + c_PH_ONE;
            r_tx_tick  <= (r_phase == c_PH_LAST);
            r_mid_tick <= (r_phase == c_PH_PRE_MID);
        end else begin
            r_tx_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
        end
    end

    assign tx_tick  = r_tx_tick;
    assign mid_tick = r_mid_tick;
    assign os_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_baud_tick_gen
//  Description : Self-checking bench for uart_baud_tick_gen (OVS=16, FRAC_W=4).
//                Stimulus pushes the expected os_tick events (edge number,
//                tx/mid flags, phase) into a queue; a monitor pops one entry
//                for every os_tick the design presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_tick_gen;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           sync;
    logic           div_load;
    logic [15:0]    clk_div;
    logic [3:0]     clk_frac;
    logic           os_tick;
    logic           tx_tick;
    logic           mid_tick;
    logic [3:0]     os_phase;

    typedef struct {
        int unsigned    edge_n;
        logic           tx;
        logic           mid;
        logic [3:0]     ph;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           mon_e;
    int unsigned    edge_no = 0;
    int             checks  = 0;
    int             errors  = 0;
    int unsigned    base;
    int unsigned    base2;

    uart_baud_tick_gen #(
        .DIV_W    (16),
        .FRAC_W   (4),
        .OVS      (16),
        .DIV_RST  (16'd1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .div_load (div_load),
        .clk_div  (clk_div),
        .clk_frac (clk_frac),
        .os_tick  (os_tick),
        .tx_tick  (tx_tick),
        .mid_tick (mid_tick),
        .os_phase (os_phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (os_tick === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: got os_tick=1 after edge %0d (ph=%0d), expected no tick",
                         edge_no, os_phase);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.edge_n != edge_no || mon_e.tx !== tx_tick ||
                    mon_e.mid !== mid_tick || mon_e.ph !== os_phase) begin
                    errors++;
                    $display("FAIL tick: got edge=%0d tx=%0b mid=%0b ph=%0d, expected edge=%0d tx=%0b mid=%0b ph=%0d",
                             edge_no, tx_tick, mid_tick, os_phase,
                             mon_e.edge_n, mon_e.tx, mon_e.mid, mon_e.ph);
                end
            end
        end else if (tx_tick === 1'b1 || mid_tick === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL orphan_tick: got tx=%0b mid=%0b with os_tick=0 after edge %0d, expected 0",
                     tx_tick, mid_tick, edge_no);
        end
    end

    // ---------------- helpers ----------------
    // Returns at 1 time unit after the rising edge numbered e.
    task automatic goto_edge(input int unsigned e);
        while (edge_no < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // n = os_tick count since the bit phase last restarted.
    task automatic push_tick(input int unsigned abs_edge, input int unsigned n);
        exp_t e;
        e.edge_n = abs_edge;
        e.ph     = 4'(n % 16);
        e.tx     = ((n % 16) == 0);
        e.mid    = ((n % 16) == 8);
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic load_div(input logic [15:0] n, input logic [3:0] f);
        en       = 1'b0;
        clk_div  = n;
        clk_frac = f;
        div_load = 1'b1;
        goto_edge(edge_no + 1);
        div_load = 1'b0;
        goto_edge(edge_no + 1);
    endtask

    task automatic stop_run(input int unsigned last_edge, input string name);
        goto_edge(last_edge);
        en = 1'b0;
        goto_edge(last_edge + 4);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d missing ticks, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        sync     = 1'b0;
        div_load = 1'b0;
        clk_div  = '0;
        clk_frac = '0;
        goto_edge(3);
        check("rst_os_tick",  32'(os_tick),  0);
        check("rst_tx_tick",  32'(tx_tick),  0);
        check("rst_mid_tick", 32'(mid_tick), 0);
        check("rst_os_phase", 32'(os_phase), 0);
        rst = 1'b0;
        goto_edge(edge_no + 1);

        // Divisor after reset is 1: a tick on every edge.
        base = edge_no;
        en   = 1'b1;
        for (int k = 1; k <= 3; k++) push_tick(base + k, k);
        stop_run(base + 3, "div_rst");

        // N=4, F=0: ticks every 4 edges, mid at 32, tx at 64 and 128.
        load_div(16'd4, 4'd0);
        base = edge_no;
        en   = 1'b1;
        for (int k = 1; k <= 32; k++) push_tick(base + 4 * k, k);
        stop_run(base + 130, "n4");

        // N=4, F=8: 4.5-cycle average period.
        load_div(16'd4, 4'd8);
        base = edge_no;
        en   = 1'b1;
        push_tick(base + 4, 1);
        push_tick(base + 8, 2);
        push_tick(base + 13, 3);
        push_tick(base + 17, 4);
        push_tick(base + 22, 5);
        push_tick(base + 26, 6);
        push_tick(base + 31, 7);
        stop_run(base + 33, "frac");

        // N=0 behaves as 1: tick every edge, tx every 16.
        load_div(16'd0, 4'd0);
        base = edge_no;
        en   = 1'b1;
        for (int k = 1; k <= 40; k++) push_tick(base + k, k);
        stop_run(base + 40, "n0");

        // N=10 with sync at edge 25.
        load_div(16'd10, 4'd0);
        base = edge_no;
        en   = 1'b1;
        push_tick(base + 10, 1);
        push_tick(base + 20, 2);
        for (int k = 1; k <= 8; k++) push_tick(base + 24 + 10 * k, k);
        goto_edge(base + 24);
        sync = 1'b1;
        goto_edge(base + 25);
        sync = 1'b0;
        check("sync_os_tick", 32'(os_tick),  0);
        check("sync_phase",   32'(os_phase), 0);
        stop_run(base + 104, "sync");

        // Running at N=4, reload N=6 at edge 6.
        load_div(16'd4, 4'd0);
        base = edge_no;
        en   = 1'b1;
        push_tick(base + 4, 1);
        push_tick(base + 8, 2);
        push_tick(base + 14, 3);
        push_tick(base + 20, 4);
        push_tick(base + 26, 5);
        goto_edge(base + 5);
        clk_div  = 16'd6;
        div_load = 1'b1;
        goto_edge(base + 6);
        div_load = 1'b0;
        stop_run(base + 26, "reload");

        // en dropped mid-bit, then rst while running.
        load_div(16'd4, 4'd0);
        base = edge_no;
        en   = 1'b1;
        push_tick(base + 4, 1);
        push_tick(base + 8, 2);
        goto_edge(base + 9);
        en = 1'b0;
        goto_edge(base + 13);
        check("en_low_phase", 32'(os_phase), 0);
        base2 = edge_no;
        en    = 1'b1;
        push_tick(base2 + 4, 1);
        goto_edge(base2 + 5);
        rst = 1'b1;
        goto_edge(base2 + 6);
        rst = 1'b0;
        check("post_rst_os_tick", 32'(os_tick),  0);
        check("post_rst_phase",   32'(os_phase), 0);
        for (int k = 1; k <= 20; k++) push_tick(base2 + 6 + k, k);
        stop_run(base2 + 26, "rst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
